// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank and its WB/decode neighbours.
package reg_bank_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 3;

    typedef enum logic {
        IDLE,
        SWEEP
    } sweep_state_e;

endpackage

// File: rtl/reg_bank_mux2.sv
// Two-input select used for the write-to-read bypass on each read port.
module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/reg_bank.sv
// Architectural register file fed by WB: two bypassed read ports, register 0
// hardwired to zero, and a soft-clear sweep that zeroes one register per cycle.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  writeReg,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    input  logic                  clearReq,
    output logic                  busy
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    sweep_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  writeEn;
    logic                  bypass1, bypass2;

    assign writeEn = writeReg && (rd != '0);
    assign bypass1 = writeEn && (rs1 == rd);
    assign bypass2 = writeEn && (rs2 == rd);
    assign busy    = busy_q;

    // A WB write to the index being swept takes priority over the clear.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (writeEn && (rd == ADDR_WIDTH'(i))) begin
                regs_d[i] = writeData;
            end else if ((state_q == SWEEP) && (idx_q == ADDR_WIDTH'(i))) begin
                regs_d[i] = '0;
            end
        end
        regs_d[0] = '0;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (clearReq) begin
                    state_d = SWEEP;
                    idx_d   = FIRST_IDX;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q  <= '{default: '0};
            state_q <= IDLE;
            idx_q   <= FIRST_IDX;
            busy_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // regs_q[0] never leaves zero, so index 0 reads need no special case here.
    mux2 #(.WIDTH(DATA_WIDTH)) u_mux1 (
        .sel_i (bypass1),
        .a_i   (regs_q[rs1]),
        .b_i   (writeData),
        .y_o   (readData1)
    );

    mux2 #(.WIDTH(DATA_WIDTH)) u_mux2 (
        .sel_i (bypass2),
        .a_i   (regs_q[rs2]),
        .b_i   (writeData),
        .y_o   (readData2)
    );

endmodule
